// File: rtl/exe_mem_skid_reg_pkg.sv
// ============================================================================
// Module   : exe_mem_skid_reg_pkg
// Brief    : Shared widths, payload control-bit order and state encoding for
//            the EXE/MEM skid pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_mem_skid_reg_pkg;

    localparam int c_SIZE         = 32;
    localparam int c_REG_ADDR_LEN = 5;

    // Control bits occupy the low end of the packed payload in this order.
    localparam int c_CTRL_MW   = 0;
    localparam int c_CTRL_MR   = 1;
    localparam int c_CTRL_WB   = 2;
    localparam int c_CTRL_BITS = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Packed payload layout (MSB..LSB): pc, alu_res, st_val, dest, ctrl.
    function automatic int payload_width(input int size, input int reg_addr_len);
        return 3 * size + reg_addr_len + c_CTRL_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exe_mem_skid_reg_if.sv
// ============================================================================
// Module   : exe_mem_skid_reg_if
// Brief    : EXE-side and MEM-side valid/ready handshake plus payload bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exe_mem_skid_reg_if
    import exe_mem_skid_reg_pkg::*;
#(
    parameter int SIZE         = c_SIZE,
    parameter int REG_ADDR_LEN = c_REG_ADDR_LEN
) ();

    logic                    valid_in;
    logic                    ready_out;
    logic [SIZE-1:0]         alu_res_in;
    logic [SIZE-1:0]         st_val_in;
    logic [REG_ADDR_LEN-1:0] dest_in;
    logic                    wb_en_in;
    logic                    mem_r_en_in;
    logic                    mem_w_en_in;
    logic [SIZE-1:0]         pc_in;

    logic                    valid_out;
    logic                    ready_in;
    logic [SIZE-1:0]         alu_res;
    logic [SIZE-1:0]         st_val;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic [SIZE-1:0]         pc;

    modport slave (
        input  valid_in, alu_res_in, st_val_in, dest_in, wb_en_in,
               mem_r_en_in, mem_w_en_in, pc_in, ready_in,
        output ready_out, valid_out, alu_res, st_val, dest, wb_en,
               mem_r_en, mem_w_en, pc
    );

    modport master (
        output valid_in, alu_res_in, st_val_in, dest_in, wb_en_in,
               mem_r_en_in, mem_w_en_in, pc_in, ready_in,
        input  ready_out, valid_out, alu_res, st_val, dest, wb_en,
               mem_r_en, mem_w_en, pc
    );

endinterface

`default_nettype wire

// File: rtl/exe_mem_skid_reg_pipe_entry_reg.sv
// ============================================================================
// Module   : pipe_entry_reg
// Brief    : Single valid+payload storage entry with load, clear (priority)
//            and asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_entry_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_d,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_q
);

    logic             r_valid;
    logic [WIDTH-1:0] r_q;

    // Clear only drops the valid bit; the payload keeps its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_q     <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;

endmodule

`default_nettype wire

// File: rtl/exe_mem_skid_reg.sv
// ============================================================================
// Module   : exe_mem_skid_reg
// Brief    : Two-entry EXE->MEM skid pipeline register with registered
//            ready_out and synchronous flush. Optional stall counter under
//            MEM_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_mem_skid_reg
    import exe_mem_skid_reg_pkg::*;
#(
    parameter int SIZE         = c_SIZE,
    parameter int REG_ADDR_LEN = c_REG_ADDR_LEN
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           i_flush,
`ifdef MEM_STALL_CNT_EN
    output logic [31:0]         o_stall_cycles,
`endif
    exe_mem_skid_reg_if.slave   bus
);

    localparam int c_PW = payload_width(SIZE, REG_ADDR_LEN);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ready_out;
    logic              w_main_valid, w_skid_valid;
    logic [c_PW-1:0]   w_main_q, w_skid_q, w_main_d, w_in_payload;
    logic              w_main_load, w_main_clear, w_skid_load, w_skid_clear;
    logic [c_CTRL_BITS-1:0] w_in_ctrl, w_main_ctrl;
    logic              w_accept, w_drain;

    assign w_in_ctrl[c_CTRL_WB] = bus.wb_en_in;
    assign w_in_ctrl[c_CTRL_MR] = bus.mem_r_en_in;
    assign w_in_ctrl[c_CTRL_MW] = bus.mem_w_en_in;
    assign w_in_payload = {bus.pc_in, bus.alu_res_in, bus.st_val_in, bus.dest_in, w_in_ctrl};

    assign w_accept = bus.valid_in && r_ready_out;
    assign w_drain  = w_main_valid && bus.ready_in;

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_d     = w_in_payload;
        w_state_nxt  = r_state;
        if (i_flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
            w_state_nxt  = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_drain) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready_out is low here, so only the skid->main shift can happen.
                    if (w_drain) begin
                        w_main_load  = 1'b1;
                        w_main_d     = w_skid_q;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = ST_ONE;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_ready_out <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_ready_out <= (w_state_nxt != ST_FULL);
        end
    end

    pipe_entry_reg #(.WIDTH(c_PW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_d     (w_main_d),
        .o_valid (w_main_valid),
        .o_q     (w_main_q)
    );

    pipe_entry_reg #(.WIDTH(c_PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     (w_in_payload),
        .o_valid (w_skid_valid),
        .o_q     (w_skid_q)
    );

    assign w_main_ctrl   = w_main_q[c_CTRL_BITS-1:0];
    assign bus.ready_out = r_ready_out;
    assign bus.valid_out = w_main_valid;
    assign bus.dest      = w_main_q[c_CTRL_BITS +: REG_ADDR_LEN];
    assign bus.st_val    = w_main_q[c_CTRL_BITS + REG_ADDR_LEN +: SIZE];
    assign bus.alu_res   = w_main_q[c_CTRL_BITS + REG_ADDR_LEN + SIZE +: SIZE];
    assign bus.pc        = w_main_q[c_CTRL_BITS + REG_ADDR_LEN + 2*SIZE +: SIZE];
    // Bubbles must look like NOPs downstream.
    assign bus.wb_en     = w_main_ctrl[c_CTRL_WB] & w_main_valid;
    assign bus.mem_r_en  = w_main_ctrl[c_CTRL_MR] & w_main_valid;
    assign bus.mem_w_en  = w_main_ctrl[c_CTRL_MW] & w_main_valid;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (w_main_valid && !bus.ready_in && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    // Skid valid is mirrored by r_state; keep it observed for lint.
    logic w_unused;
    assign w_unused = w_skid_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exe_mem_skid_reg.sv
// ============================================================================
// Module   : tb_exe_mem_skid_reg
// Brief    : Self-checking bench for exe_mem_skid_reg against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_mem_skid_reg;
    import exe_mem_skid_reg_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic i_flush;
    logic [31:0] o_stall_cycles;

    exe_mem_skid_reg_if bus ();

`ifdef MEM_STALL_CNT_EN
    exe_mem_skid_reg dut (.clk(clk), .rst(rst), .i_flush(i_flush), .o_stall_cycles(o_stall_cycles), .bus(bus));
`else
    exe_mem_skid_reg dut (.clk(clk), .rst(rst), .i_flush(i_flush), .bus(bus));
    assign o_stall_cycles = 32'd0;
`endif

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    beat_t m_last;
    logic [31:0] m_stall;

    task automatic drive(input logic v, input logic [31:0] alu, input logic wb, input logic mw);
        bus.valid_in    = v;
        bus.alu_res_in  = alu;
        bus.st_val_in   = alu ^ 32'hA5A5_0000;
        bus.pc_in       = alu << 2;
        bus.dest_in     = alu[4:0];
        bus.wb_en_in    = wb;
        bus.mem_r_en_in = 1'b0;
        bus.mem_w_en_in = mw;
    endtask

    task automatic model_reset();
        q.delete();
        m_last  = '0;
        m_stall = '0;
    endtask

    // One clock with inputs already applied; the model advances alongside.
    task automatic step(input logic fl);
        beat_t inb;
        logic  acc, drn;
        inb = {bus.pc_in, bus.alu_res_in, bus.st_val_in, bus.dest_in,
               bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in};
        acc = bus.valid_in && (q.size() < 2);
        drn = (q.size() > 0) && bus.ready_in;
        if ((q.size() > 0) && !bus.ready_in && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        i_flush = fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(inb);
        end
        if (q.size() > 0) m_last = q[0];
        #1;
        i_flush = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: valid_out=%b ready_out=%b, want 0/1", bus.valid_out, bus.ready_out);
        end
        checks++;
        if ({bus.alu_res, bus.st_val, bus.pc, bus.dest, bus.wb_en, bus.mem_r_en, bus.mem_w_en} !== '0) begin
            errors++;
            $display("FAIL reset_payload: alu=%h st=%h pc=%h dest=%h ctrl=%b%b%b, want all 0",
                     bus.alu_res, bus.st_val, bus.pc, bus.dest, bus.wb_en, bus.mem_r_en, bus.mem_w_en);
        end
    endtask

    task automatic test_streaming();
        bus.ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, 1'b1, 1'b0);
            step(1'b0);
            checks++;
            if (bus.valid_out !== 1'b1 || bus.alu_res !== 32'(i) || bus.ready_out !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b alu=%h ready=%b, want 1/%h/1",
                         i, bus.valid_out, bus.alu_res, bus.ready_out, i);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        step(1'b0);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: valid=%b want 0", bus.valid_out);
        end
    endtask

    task automatic test_backpressure();
        bus.ready_in = 1'b0;
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b0);
        checks++;
        if (bus.ready_out !== 1'b1 || bus.alu_res !== 32'h10 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_a: ready=%b alu=%h valid=%b, want 1/10/1", bus.ready_out, bus.alu_res, bus.valid_out);
        end
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        step(1'b0);
        checks++;
        if (bus.ready_out !== 1'b0 || bus.alu_res !== 32'h10) begin
            errors++;
            $display("FAIL bp_full: ready=%b alu=%h, want 0/10", bus.ready_out, bus.alu_res);
        end
        drive(1'b0, 32'h30, 1'b0, 1'b0);
        repeat (2) step(1'b0);
        checks++;
        if (bus.alu_res !== 32'h10 || bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: alu=%h valid=%b ready=%b, want 10/1/0", bus.alu_res, bus.valid_out, bus.ready_out);
        end
        bus.ready_in = 1'b1;
        step(1'b0);
        checks++;
        if (bus.alu_res !== 32'h20 || bus.valid_out !== 1'b1 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: alu=%h valid=%b ready=%b, want 20/1/1", bus.alu_res, bus.valid_out, bus.ready_out);
        end
        step(1'b0);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b want 0", bus.valid_out);
        end
    endtask

    task automatic test_flush();
        bus.ready_in = 1'b0;
        drive(1'b1, 32'h41, 1'b1, 1'b1);
        step(1'b0);
        drive(1'b1, 32'h42, 1'b1, 1'b1);
        step(1'b0);
        drive(1'b1, 32'hDEAD, 1'b1, 1'b1);
        step(1'b1);
        checks++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1 || bus.wb_en !== 1'b0 || bus.mem_w_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: valid=%b ready=%b wb=%b mw=%b, want 0/1/0/0",
                     bus.valid_out, bus.ready_out, bus.wb_en, bus.mem_w_en);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        bus.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            checks++;
            if (bus.valid_out !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost_%0d: valid=%b alu=%h, want valid 0", i, bus.valid_out, bus.alu_res);
            end
        end
    endtask

    task automatic test_bubble();
        bus.ready_in = 1'b1;
        drive(1'b1, 32'h55, 1'b1, 1'b1);
        step(1'b0);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.wb_en !== 1'b1 || bus.mem_w_en !== 1'b1) begin
            errors++;
            $display("FAIL bubble_head: valid=%b wb=%b mw=%b, want 1/1/1", bus.valid_out, bus.wb_en, bus.mem_w_en);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        step(1'b0);
        checks++;
        if (bus.valid_out !== 1'b0 || bus.wb_en !== 1'b0 || bus.mem_w_en !== 1'b0 || bus.alu_res !== 32'h55) begin
            errors++;
            $display("FAIL bubble_mask: valid=%b wb=%b mw=%b alu=%h, want 0/0/0/55",
                     bus.valid_out, bus.wb_en, bus.mem_w_en, bus.alu_res);
        end
    endtask

    task automatic test_async_reset();
        bus.ready_in = 1'b0;
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        step(1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.alu_res !== 32'h0 || bus.wb_en !== 1'b0 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: valid=%b alu=%h wb=%b ready=%b, want 0/0/0/1",
                     bus.valid_out, bus.alu_res, bus.wb_en, bus.ready_out);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ready_in = 1'b1;
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        step(1'b0);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.alu_res !== 32'h99) begin
            errors++;
            $display("FAIL async_rst_first: valid=%b alu=%h, want 1/99", bus.valid_out, bus.alu_res);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        step(1'b0);
    endtask

    task automatic test_random();
        beat_t exp_b, act_b;
        logic  exp_v;
        for (int n = 0; n < 400; n++) begin
            bus.valid_in    = ($urandom_range(0, 3) != 0);
            bus.ready_in    = ($urandom_range(0, 2) != 0);
            bus.alu_res_in  = $urandom;
            bus.st_val_in   = $urandom;
            bus.pc_in       = $urandom;
            bus.dest_in     = 5'($urandom);
            bus.wb_en_in    = 1'($urandom);
            bus.mem_r_en_in = 1'($urandom);
            bus.mem_w_en_in = 1'($urandom);
            step($urandom_range(0, 15) == 0);
            exp_v = (q.size() > 0);
            exp_b = exp_v ? q[0] : m_last;
            exp_b.wb &= exp_v;
            exp_b.mr &= exp_v;
            exp_b.mw &= exp_v;
            act_b = {bus.pc, bus.alu_res, bus.st_val, bus.dest, bus.wb_en, bus.mem_r_en, bus.mem_w_en};
            checks++;
            if (bus.valid_out !== exp_v || bus.ready_out !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rand_hs[%0d]: valid=%b ready=%b, want %b/%b", n, bus.valid_out, bus.ready_out, exp_v, q.size() < 2);
            end
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL rand_payload[%0d]: got %h want %h", n, act_b, exp_b);
            end
`ifdef MEM_STALL_CNT_EN
            checks++;
            if (o_stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL rand_stall[%0d]: got %0d want %0d", n, o_stall_cycles, m_stall);
            end
`endif
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        bus.ready_in = 1'b1;
        repeat (3) step(1'b0);
    endtask

`ifdef MEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        pulse_reset();
        bus.ready_in = 1'b0;
        drive(1'b1, 32'hC0, 1'b0, 1'b0);
        step(1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (7) step(1'b0);
        checks++;
        if (o_stall_cycles !== 32'd7 || m_stall !== 32'd7) begin
            errors++;
            $display("FAIL stall_7: got %0d model %0d want 7", o_stall_cycles, m_stall);
        end
        bus.ready_in = 1'b1;
        step(1'b1);
        step(1'b0);
        checks++;
        if (o_stall_cycles !== 32'd7) begin
            errors++;
            $display("FAIL stall_flush: got %0d want 7", o_stall_cycles);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (o_stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL stall_reset: got %0d want 0", o_stall_cycles);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b0;
        i_flush      = 1'b0;
        bus.ready_in = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_async_reset();
        pulse_reset();
        test_random();
`ifdef MEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exe_mem_skid_reg.md
Name: exe_mem_skid_reg

Overview:
- Pipeline register between the EXE stage (ALU result, store value, destination, control) and the MEM stage.
- Two-entry skid buffer with valid/ready handshake on both sides. The EXE stage can therefore complete one more instruction when data memory (SRAM) back-pressures, with no combinational ready path from MEM to EXE.
- Synchronous flush kills in-flight entries on branch/exception.

Parameters:
- SIZE, 32, datapath width (ALU result, store value, PC).
- REG_ADDR_LEN, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all stored entries and of the incoming beat.
- valid_in  input  1  EXE presents an instruction.
- ready_out  output  1  block can accept; registered.
- alu_res_in  input  SIZE  ALU output.
- st_val_in  input  SIZE  store data.
- dest_in  input  REG_ADDR_LEN  writeback register.
- wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control bits.
- pc_in  input  SIZE  instruction PC.
- valid_out  output  1  head entry valid.
- ready_in  input  1  MEM stage accepts head.
- alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en, pc  output  same widths  head-entry payload.
- stall_cycles  output  32  present only with MEM_STALL_CNT_EN.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Handshake:
  - accept = valid_in && ready_out.
  - drain = valid_out && ready_in.
  - Payload must stay stable while valid_out=1 and ready_in=0.
- ready_out = !skid_valid, registered. It is 1 in EMPTY and ONE, 0 in FULL.
- Transitions (flush=0):
  - EMPTY: accept → main<=in, ONE.
  - ONE, accept && drain → main<=in, stay ONE.
  - ONE, accept && !drain → skid<=in, FULL.
  - ONE, !accept && drain → EMPTY.
  - FULL, drain → main<=skid, skid invalid, ONE. No accept is possible in FULL.
- Latency: an accepted beat appears on valid_out the next cycle when it lands in main. Throughput is 1/cycle with ready_in held high.
- Order: strictly FIFO; the skid entry never overtakes main.
- Control masking: wb_en, mem_r_en and mem_w_en outputs are ANDed with valid_out, so a bubble is a NOP for MEM/WB. Data outputs hold their last value when invalid.
- Flush:
  - Highest priority. Next cycle both valid bits are 0, state is EMPTY and ready_out is 1.
  - A beat accepted in the flush cycle is discarded.
  - A head drained in the flush cycle is still considered consumed by MEM (the handshake is combinational that cycle).
- Reset (rst=0, async):
  - valid bits 0, ready_out 1, all payload registers 0.
  - All control outputs 0.
  - stall_cycles 0.
- Reset mid-operation discards both entries without draining.

Optional Feature:
MEM_STALL_CNT_EN
- Defined:
  - 32-bit counter stall_cycles increments each cycle with valid_out=1 and ready_in=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset; flush does not clear it.
  - Port stall_cycles exists.
- Undefined: the counter and the port are absent. Handshake behaviour is identical.

Decomposition:
- Shared defines.v holds the widths (word size, register-address length) and the control-bit ordering of the packed payload.
- The payload packs into one vector, 3*SIZE + REG_ADDR_LEN + 3 bits.
- One natural sub-module: pipe_entry_reg. It is a single valid+payload register with load enable, clear and asynchronous active-low reset, instantiated twice (main, skid).

Test Plan:
- Streaming: ready_in=1, 4 back-to-back beats with alu_res 1,2,3,4 → valid_out one cycle after each accept; outputs 1,2,3,4 on consecutive cycles; ready_out stays 1.
- Back-pressure:
  - Accept A(alu_res=0x10), B(0x20) with ready_in=0 → ready_out falls to 0 the cycle after B.
  - Head holds 0x10 stable.
  - Raise ready_in → 0x10 then 0x20 drain in order; ready_out returns to 1.
- Flush in FULL:
  - Flush=1 while a beat is offered → next cycle valid_out=0, ready_out=1, wb_en/mem_w_en outputs 0.
  - The flushed beat never appears.
- Bubble masking: entry with wb_en=1, mem_w_en=1 drained, no new input → next cycle valid_out=0 and both control outputs 0 while alu_res holds the old value.
- Async reset in ONE: rst=0 mid-cycle → outputs and valid clear immediately without a clock edge; after release the first accepted beat appears after 1 cycle.
- MEM_STALL_CNT_EN: hold valid_out=1, ready_in=0 for 7 cycles → stall_cycles=7; flush leaves the value at 7; reset returns it to 0.
